// File: rtl/sdes_decrypt_seq.sv
// Sequential S-DES decryptor: IP, fk(K2), SW, fk(K1), IP^-1, one round per clock.
// Define SDES_KEYGEN_EN to take a 10-bit master key and derive K1/K2 internally.
module sdes_decrypt_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] c_in,
`ifdef SDES_KEYGEN_EN
    input  logic [9:0] key10,
`else
    input  logic [7:0] key_1,
    input  logic [7:0] key_2,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] plain,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RK2, RK1, OUT} state_t;

    // S-box rows packed {row0,row1,row2,row3}, each row four 2-bit entries, col 0 first
    localparam logic [31:0] S0_TBL = 32'b01001110_11100100_00100111_11011110;
    localparam logic [31:0] S1_TBL = 32'b00011011_10000111_11000100_10010011;

    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] b);
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] row_v;
        row   = {b[3], b[0]};
        col   = {b[2], b[1]};
        row_v = 8'(tbl >> {~row, 3'b000});
        return 2'(row_v >> {~col, 1'b0});
    endfunction

    // Round function F(R,K): expand, key mix, S-boxes, P4
    function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        logic [3:0] y;
        x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        y = {sbox(S0_TBL, x[7:4]), sbox(S1_TBL, x[3:0])};
        return {y[2], y[0], y[1], y[3]};
    endfunction

    state_t     state;
    logic [3:0] l_q;
    logic [3:0] r_q;
    logic [7:0] k1;
    logic [7:0] k2;

`ifdef SDES_KEYGEN_EN
    logic [9:0] key10_q;
    logic [9:0] p10;

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    // Key schedule: P10, then per-half rotate-left by 1 (K1) and by 3 in total (K2)
    always_comb begin
        p10 = {key10_q[7], key10_q[5], key10_q[8], key10_q[3], key10_q[6],
               key10_q[0], key10_q[9], key10_q[1], key10_q[2], key10_q[4]};
        k1  = p8({p10[8:5], p10[9], p10[3:0], p10[4]});
        k2  = p8({p10[6:5], p10[9:7], p10[1:0], p10[4:2]});
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            l_q       <= '0;
            r_q       <= '0;
`ifdef SDES_KEYGEN_EN
            key10_q   <= '0;
`else
            k1        <= '0;
            k2        <= '0;
`endif
            plain     <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip(c_in);
`ifdef SDES_KEYGEN_EN
                        key10_q    <= key10;
`else
                        k1         <= key_1;
                        k2         <= key_2;
`endif
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RK2;
                    end
                end
                RK2: begin
                    l_q   <= r_q;
                    r_q   <= l_q ^ f_round(r_q, k2);
                    state <= RK1;
                end
                RK1: begin
                    // Final round has no swap; result goes straight to the output register
                    plain     <= ip_inv({l_q ^ f_round(r_q, k1), r_q});
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
